flappy_game_ctrl: RTL and testbench
===================================

Name: flappy_game_ctrl

Overview:
- Top-level game sequencer for the flappy bird datapath.
- Runs the IDLE/PLAY/DEAD state machine, owns the bird's vertical position, and issues the shift enable for the 128-bit pipe shift register.
- Checks bird-vs-pipe-gap and bird-vs-floor collision and keeps the score.
- Sits between the button/frame-timing logic and the pipe register and renderer.

Parameters:
- START_Y, 240: bird top-edge y (pixels from top) on entering PLAY.
- FALL_PX, 2: downward pixels per frame tick with no flap.
- JUMP_PX, 60: upward pixels applied on a flapped frame.
- BIRD_SIZE, 30: square bird side length, pixels.
- SCREEN_H, 480: screen height, pixels; floor at y = SCREEN_H.
- SHIFT_FRAMES, 75: frame ticks between pipe shifts (300 px pitch = 240 gap + 60 width, at 4 px/frame).
- DEAD_FRAMES, 60: frame ticks in DEAD before a flap is accepted.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high; one clock domain only.
- frame_tick  input  1  one-cycle pulse per video frame.
- btn  input  1  flap button, level, already synchronised.
- pipe_here  input  1  a pipe column currently overlaps bird x (x = 160..189).
- gap_low  input  16  top y of the open gap of that pipe.
- gap_high  input  16  bottom y (exclusive) of that gap.
- bird_y  output  16  bird top-edge y.
- shift_en  output  1  one-cycle enable to the pipe shift register.
- score  output  16  pipes passed this game.
- state  output  2  00 IDLE, 01 PLAY, 10 DEAD.
- game_over  output  1  high while in DEAD.

Behaviour:
- Reset (sync, rst high at clk edge):
  - state = IDLE, bird_y = START_Y, score = 0, shift_en = 0, game_over = 0.
  - Frame counter, dead counter, btn_q and flap_pending all cleared.
  - Reset mid-game aborts immediately; the next edge after rst falls behaves as IDLE.
- Flap detect: btn_q <= btn; flap = btn & ~btn_q (rising edge only, so a held button is one flap).
- flap_pending:
  - Set on flap; cleared on frame_tick in PLAY.
  - Flap and frame_tick in the same cycle counts for that frame.
- IDLE:
  - bird_y held at START_Y; shift_en = 0.
  - flap -> PLAY next edge; score = 0, frame counter = 0, flap_pending cleared (the starting flap is not a jump).
- PLAY, on frame_tick:
  - If flap_pending: bird_y = (bird_y < JUMP_PX) ? 0 : bird_y - JUMP_PX (clamp at ceiling, no wrap).
  - Else: bird_y = bird_y + FALL_PX.
  - Frame counter increments. When it reaches SHIFT_FRAMES-1 it wraps to 0, shift_en pulses for exactly the next cycle, and score increments (saturating at 0xFFFF).
- Collision, evaluated every PLAY cycle on the registered bird_y:
  - hit = (bird_y + BIRD_SIZE >= SCREEN_H) | (pipe_here & ((bird_y < gap_low) | (bird_y + BIRD_SIZE > gap_high))).
  - Use a 17-bit sum for bird_y + BIRD_SIZE.
  - hit -> DEAD next edge.
  - hit and frame_tick in the same cycle: hit wins; bird_y, score and the frame counter do not update; no shift_en.
- DEAD:
  - game_over = 1; bird_y and score frozen; shift_en = 0.
  - Dead counter counts frame_ticks up to DEAD_FRAMES.
  - flap is ignored before the count completes; after it completes, flap -> IDLE (bird_y = START_Y, score keeps last value until the next PLAY entry).
- Outputs are registered with no combinational path input->output, except that state and game_over decode from the state register.
- shift_en is never high for two consecutive cycles.

Test Plan:
- Reset then idle: rst high 2 cycles, 10 frame_ticks, no btn -> state=00, bird_y=240, score=0, shift_en never asserted.
- Start and fall: flap in IDLE, then 5 frame_ticks with no btn, pipe_here=0 -> state=01, bird_y=250.
- Jump and ceiling clamp: bird_y=250, flap before a tick -> 190; repeated flaps -> 130, 70, 10, then 0 (clamped, no wrap); holding btn high across 3 ticks gives only one jump.
- Shift and score: 150 frame_ticks in PLAY with the bird kept in range -> exactly 2 single-cycle shift_en pulses, at ticks 75 and 150, score=2.
- Collision cases, all with gap_low=200, gap_high=290, pipe_here=1:
  - bird_y=200 -> no hit.
  - bird_y=261 -> DEAD next cycle, game_over=1, bird_y frozen.
  - bird_y=199 -> DEAD.
  - Floor: bird_y reaching 450 with pipe_here=0 -> DEAD.
- Dead lockout: in DEAD, flap after 30 ticks -> stays DEAD; flap after 60 ticks -> IDLE, bird_y=240; next flap -> PLAY with score=0.

Source files
------------

// File: rtl/flappy_game_ctrl.sv
// -----------------------------------------------------------------------------
// flappy_game_ctrl
// Top-level game sequencer for the flappy bird datapath. It runs the
// IDLE/PLAY/DEAD state machine, owns the bird's vertical position, issues the
// shift enable for the pipe shift register, checks gap/floor collisions and
// keeps the score.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   frame_tick in   one-cycle pulse per video frame
//   btn        in   flap button level (already synchronised)
//   pipe_here  in   a pipe column overlaps the bird's x span
//   gap_low    in   top y of that pipe's open gap
//   gap_high   in   bottom y (exclusive) of that gap
//   bird_y     out  bird top-edge y
//   shift_en   out  one-cycle enable to the pipe shift register
//   score      out  pipes passed this game (saturating)
//   state      out  00 IDLE, 01 PLAY, 10 DEAD
//   game_over  out  high while in DEAD
// -----------------------------------------------------------------------------
module flappy_game_ctrl #(
  parameter int unsigned START_Y      = 240,
  parameter int unsigned FALL_PX      = 2,
  parameter int unsigned JUMP_PX      = 60,
  parameter int unsigned BIRD_SIZE    = 30,
  parameter int unsigned SCREEN_H     = 480,
  parameter int unsigned SHIFT_FRAMES = 75,
  parameter int unsigned DEAD_FRAMES  = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn,
  input  logic        pipe_here,
  input  logic [15:0] gap_low,
  input  logic [15:0] gap_high,
  output logic [15:0] bird_y,
  output logic        shift_en,
  output logic [15:0] score,
  output logic [1:0]  state,
  output logic        game_over
);

  localparam logic [15:0] START_Y_C    = 16'(START_Y);
  localparam logic [15:0] FALL_C       = 16'(FALL_PX);
  localparam logic [15:0] JUMP_C       = 16'(JUMP_PX);
  localparam logic [16:0] BIRD_SIZE_C  = 17'(BIRD_SIZE);
  localparam logic [16:0] SCREEN_H_C   = 17'(SCREEN_H);
  localparam logic [15:0] SHIFT_LAST_C = 16'(SHIFT_FRAMES - 1);
  localparam logic [15:0] DEAD_C       = 16'(DEAD_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_DEAD = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] bird_y_q, bird_y_d;
  logic [15:0] score_q, score_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] dead_cnt_q, dead_cnt_d;
  logic        shift_en_q, shift_en_d;
  logic        flap_pending_q, flap_pending_d;
  logic        btn_q;

  logic        flap;
  logic [16:0] bird_bot;
  logic        hit;
  logic        jump;
  logic [15:0] y_jump;
  logic [15:0] y_fall;
  logic [15:0] score_inc;
  logic        shift_wrap;
  logic        dead_done;

  // Rising edge of the button only, so a held button is a single flap.
  assign flap = btn & ~btn_q;

  // 17-bit bottom edge so the floor compare cannot wrap near 0xFFFF.
  assign bird_bot = {1'b0, bird_y_q} + BIRD_SIZE_C;
  assign hit      = (bird_bot >= SCREEN_H_C) |
                    (pipe_here & ((bird_y_q < gap_low) |
                                  (bird_bot > {1'b0, gap_high})));

  // A flap arriving in the same cycle as the tick still counts for that frame.
  assign jump       = flap_pending_q | flap;
  assign y_jump     = (bird_y_q < JUMP_C) ? 16'd0 : bird_y_q - JUMP_C;
  assign y_fall     = bird_y_q + FALL_C;
  assign score_inc  = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
  assign shift_wrap = (frame_cnt_q == SHIFT_LAST_C);
  assign dead_done  = (dead_cnt_q == DEAD_C);

  always_comb begin
    state_d        = state_q;
    bird_y_d       = bird_y_q;
    score_d        = score_q;
    frame_cnt_d    = frame_cnt_q;
    dead_cnt_d     = dead_cnt_q;
    shift_en_d     = 1'b0;
    flap_pending_d = flap_pending_q;

    unique case (state_q)
      ST_IDLE: begin
        bird_y_d       = START_Y_C;
        flap_pending_d = 1'b0;
        if (flap) begin
          // The starting flap launches the game but is not a jump.
          state_d     = ST_PLAY;
          score_d     = 16'd0;
          frame_cnt_d = 16'd0;
        end
      end

      ST_PLAY: begin
        if (hit) begin
          // Collision takes priority over any same-cycle frame update.
          state_d        = ST_DEAD;
          dead_cnt_d     = 16'd0;
          flap_pending_d = 1'b0;
        end else if (frame_tick) begin
          bird_y_d       = jump ? y_jump : y_fall;
          flap_pending_d = 1'b0;
          if (shift_wrap) begin
            frame_cnt_d = 16'd0;
            shift_en_d  = 1'b1;
            score_d     = score_inc;
          end else begin
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end else if (flap) begin
          flap_pending_d = 1'b1;
        end
      end

      ST_DEAD: begin
        flap_pending_d = 1'b0;
        if (frame_tick && !dead_done) begin
          dead_cnt_d = dead_cnt_q + 16'd1;
        end
        // Score is left showing until the next game actually starts.
        if (flap && dead_done) begin
          state_d  = ST_IDLE;
          bird_y_d = START_Y_C;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      bird_y_q       <= START_Y_C;
      score_q        <= 16'd0;
      frame_cnt_q    <= 16'd0;
      dead_cnt_q     <= 16'd0;
      shift_en_q     <= 1'b0;
      flap_pending_q <= 1'b0;
      btn_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      bird_y_q       <= bird_y_d;
      score_q        <= score_d;
      frame_cnt_q    <= frame_cnt_d;
      dead_cnt_q     <= dead_cnt_d;
      shift_en_q     <= shift_en_d;
      flap_pending_q <= flap_pending_d;
      btn_q          <= btn;
    end
  end

  assign bird_y    = bird_y_q;
  assign shift_en  = shift_en_q;
  assign score     = score_q;
  assign state     = state_q;
  assign game_over = (state_q == ST_DEAD);

endmodule

// File: tb/tb_flappy_game_ctrl.sv
module tb_flappy_game_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        btn;
  logic        pipe_here;
  logic [15:0] gap_low;
  logic [15:0] gap_high;
  logic [15:0] bird_y;
  logic        shift_en;
  logic [15:0] score;
  logic [1:0]  state;
  logic        game_over;

  int checks = 0;
  int failures = 0;
  int shift_seen = 0;
  logic prev_shift = 1'b0;

  // Reference trackers for the current game.
  int model_y;
  int game_ticks;
  int model_score;

  flappy_game_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .btn       (btn),
    .pipe_here (pipe_here),
    .gap_low   (gap_low),
    .gap_high  (gap_high),
    .bird_y    (bird_y),
    .shift_en  (shift_en),
    .score     (score),
    .state     (state),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Pulse counter and back-to-back guard on shift_en.
  always @(negedge clk) begin
    if (shift_en) begin
      shift_seen++;
      chk("shift_single", {31'd0, prev_shift}, 32'd0);
    end
    prev_shift = shift_en;
  end

  task automatic flap_press();
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    @(negedge clk);
  endtask

  // Frame tick outside PLAY: shift_en must stay low.
  task automatic pulse_tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("shift_off", {31'd0, shift_en}, 32'd0);
    @(negedge clk);
  endtask

  // Frame tick in PLAY, optionally with a same-cycle flap.
  task automatic play_tick(input bit flp);
    btn = flp;
    frame_tick = 1'b1;
    game_ticks++;
    if (flp) model_y = (model_y < 60) ? 0 : model_y - 60;
    else     model_y = model_y + 2;
    if (game_ticks % 75 == 0) model_score++;
    @(negedge clk);
    frame_tick = 1'b0;
    btn = 1'b0;
    chk("shift_tick", {31'd0, shift_en}, (game_ticks % 75 == 0) ? 32'd1 : 32'd0);
    @(negedge clk);
  endtask

  task automatic goto_y(input int target);
    int guard = 0;
    while (model_y != target && guard < 500) begin
      play_tick(model_y > target);
      guard++;
    end
    chk("goto_y", {16'd0, bird_y}, target);
  endtask

  task automatic new_game_model();
    model_y = 240;
    game_ticks = 0;
    model_score = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_jump [5] = '{190, 130, 70, 10, 0};
    rst = 1'b1; frame_tick = 1'b0; btn = 1'b0;
    pipe_here = 1'b0; gap_low = 16'd0; gap_high = 16'd0;
    new_game_model();

    // Reset and idle
    @(negedge clk);
    @(negedge clk);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_bird", {16'd0, bird_y}, 32'd240);
    chk("rst_score", {16'd0, score}, 32'd0);
    chk("rst_shift", {31'd0, shift_en}, 32'd0);
    chk("rst_over", {31'd0, game_over}, 32'd0);
    rst = 1'b0;
    repeat (10) pulse_tick();
    chk("idle_state", {30'd0, state}, 32'd0);
    chk("idle_bird", {16'd0, bird_y}, 32'd240);
    chk("idle_shifts", shift_seen, 32'd0);

    // Start and fall
    flap_press();
    chk("start_state", {30'd0, state}, 32'd1);
    chk("start_bird", {16'd0, bird_y}, 32'd240);
    repeat (5) play_tick(1'b0);
    chk("fall_bird", {16'd0, bird_y}, 32'd250);

    // Jumps down to the ceiling clamp
    for (int i = 0; i < 5; i++) begin
      play_tick(1'b1);
      chk("jump_bird", {16'd0, bird_y}, exp_jump[i]);
    end

    // Held button across three ticks: one jump (clamped), then two falls
    btn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
    btn = 1'b0;
    game_ticks += 3;
    model_y = 4;
    chk("hold_bird", {16'd0, bird_y}, 32'd4);

    // Shift and score up to tick 150
    while (game_ticks < 150) play_tick(model_y >= 300);
    chk("score_150", {16'd0, score}, 32'd2);
    chk("shifts_150", shift_seen, 32'd2);
    chk("play_state", {30'd0, state}, 32'd1);

    // Gap top edge: 200 inside, then gap_low raised to 201 with a same-cycle tick
    goto_y(200);
    pipe_here = 1'b1; gap_low = 16'd200; gap_high = 16'd290;
    @(negedge clk);
    @(negedge clk);
    chk("gap_top_ok", {30'd0, state}, 32'd1);
    gap_low = 16'd201;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("hit_noshift", {31'd0, shift_en}, 32'd0);
    @(negedge clk);
    chk("hit_top_state", {30'd0, state}, 32'd2);
    chk("hit_top_over", {31'd0, game_over}, 32'd1);
    chk("hit_top_bird", {16'd0, bird_y}, 32'd200);
    chk("hit_top_score", {16'd0, score}, model_score);
    pipe_here = 1'b0;

    // Dead lockout: 30, then 59, then 60 ticks
    repeat (30) pulse_tick();
    flap_press();
    chk("dead_30", {30'd0, state}, 32'd2);
    repeat (29) pulse_tick();
    flap_press();
    chk("dead_59", {30'd0, state}, 32'd2);
    chk("dead_bird", {16'd0, bird_y}, 32'd200);
    pulse_tick();
    flap_press();
    chk("dead_60_state", {30'd0, state}, 32'd0);
    chk("dead_60_bird", {16'd0, bird_y}, 32'd240);
    chk("idle_keep_score", {16'd0, score}, model_score);
    flap_press();
    chk("replay_state", {30'd0, state}, 32'd1);
    chk("replay_score", {16'd0, score}, 32'd0);
    new_game_model();

    // Gap bottom edge: 260+30=290 inside, then gap_high 289 hits
    goto_y(260);
    pipe_here = 1'b1; gap_low = 16'd200; gap_high = 16'd290;
    @(negedge clk);
    @(negedge clk);
    chk("gap_bot_ok", {30'd0, state}, 32'd1);
    gap_high = 16'd289;
    @(negedge clk);
    @(negedge clk);
    chk("hit_bot_state", {30'd0, state}, 32'd2);
    chk("hit_bot_bird", {16'd0, bird_y}, 32'd260);
    pipe_here = 1'b0;
    repeat (60) pulse_tick();
    flap_press();
    chk("dead2_idle", {30'd0, state}, 32'd0);
    flap_press();
    chk("play3_state", {30'd0, state}, 32'd1);
    new_game_model();

    // Floor: 240 + 2*105 = 450 hits the floor
    repeat (104) play_tick(1'b0);
    chk("pre_floor_state", {30'd0, state}, 32'd1);
    chk("pre_floor_bird", {16'd0, bird_y}, 32'd448);
    play_tick(1'b0);
    chk("floor_state", {30'd0, state}, 32'd2);
    chk("floor_over", {31'd0, game_over}, 32'd1);
    chk("floor_bird", {16'd0, bird_y}, 32'd450);
    chk("floor_score", {16'd0, score}, 32'd1);

    // Reset while dead
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_state", {30'd0, state}, 32'd0);
    chk("midrst_bird", {16'd0, bird_y}, 32'd240);
    chk("midrst_score", {16'd0, score}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_over", {31'd0, game_over}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
